// File: rtl/multi_display.sv
// Time-multiplexed common-anode 7-segment driver with PWM brightness,
// per-digit blink, leading-zero suppression and a guard cycle between digits.
module multi_display #(
  parameter int DIGITS       = 4,
  parameter int FREQ         = 10000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   dat,
  input  logic [DIGITS-1:0]     en_in,
  input  logic [DIGITS-1:0]     dp,
  input  logic [DIGITS-1:0]     blink,
  input  logic [3:0]            bright,
  input  logic                  lz_sup,
  output logic [DIGITS-1:0]     sel,
  output logic [7:0]            c
);

  localparam int SLICE = FREQ / (SCAN_HZ * 16);
  localparam int SW = (SLICE > 1) ? $clog2(SLICE) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [SW-1:0] slice_cnt;
  logic [3:0]    phase;
  logic [IW-1:0] idx;
  logic [FW-1:0] frame_cnt;
  logic          blink_ph;

  logic slice_wrap;
  logic dwell_end;
  logic frame_end;

  assign slice_wrap = (slice_cnt == SW'(SLICE - 1));
  assign dwell_end  = slice_wrap && (phase == 4'hF);
  assign frame_end  = dwell_end && (idx == IW'(DIGITS - 1));

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [3:0]        nib;
  logic              sup;
  logic              dark;
  logic [DIGITS-1:0] sel_d;
  logic [7:0]        c_d;

  always_comb begin
    nib = dat[4*int'(idx) +: 4];
    // suppress only when this digit and everything to its left is zero
    sup = lz_sup && (idx != '0);
    for (int j = 0; j < DIGITS; j++) begin
      if (j >= int'(idx) && dat[4*j +: 4] != 4'd0) sup = 1'b0;
    end
    dark = !en_in[idx]
        || (blink[idx] && blink_ph)
        || (phase > bright)
        || (slice_cnt == '0 && phase == 4'd0);
    sel_d = '1;
    c_d   = 8'hFF;
    if (!dark) begin
      sel_d = ~(DIGITS'(1) << idx);
      c_d   = {~dp[idx], sup ? 7'h7F : hex7(nib)};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      slice_cnt <= '0;
      phase     <= '0;
      idx       <= '0;
      frame_cnt <= '0;
      blink_ph  <= 1'b0;
      sel       <= '1;
      c         <= 8'hFF;
    end else begin
      sel       <= sel_d;
      c         <= c_d;
      slice_cnt <= slice_wrap ? '0 : slice_cnt + 1'b1;
      if (slice_wrap) phase <= phase + 4'd1;
      if (dwell_end) begin
        idx <= (idx == IW'(DIGITS - 1)) ? '0 : idx + 1'b1;
      end
      if (frame_end) begin
        if (frame_cnt == FW'(BLINK_FRAMES - 1)) begin
          frame_cnt <= '0;
          blink_ph  <= ~blink_ph;
        end else begin
          frame_cnt <= frame_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_multi_display.sv
// Bench for multi_display: vector table, scan-timing sequences and a
// cycle-count based reference model checked every clock.
module tb_multi_display;

  localparam int D  = 4;
  localparam int SL = 10;
  localparam int DW = 16 * SL;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] dat = 16'h0;
  logic [3:0]  en_in = 4'hF;
  logic [3:0]  dp = 4'h0;
  logic [3:0]  blink = 4'h0;
  logic [3:0]  bright = 4'hF;
  logic        lz_sup = 1'b0;
  logic [3:0]  sel;
  logic [7:0]  c;

  multi_display #(
    .DIGITS(D), .FREQ(1600), .SCAN_HZ(10), .BLINK_FRAMES(BF)
  ) dut (
    .clk(clk), .rst(rst), .dat(dat), .en_in(en_in), .dp(dp),
    .blink(blink), .bright(bright), .lz_sup(lz_sup),
    .sel(sel), .c(c)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n      = 0;
  int last_n = 0;

  logic [7:0] seg_lut [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  // expected {sel,c} for the scan position k active edges after reset
  function automatic logic [11:0] model(input int k);
    int sl, ph, id, bph;
    logic drk, sp;
    logic [7:0] s;
    sl  = k % SL;
    ph  = (k / SL) % 16;
    id  = (k / DW) % D;
    bph = ((k / (DW * D)) / BF) % 2;
    drk = !en_in[id] || (blink[id] && bph == 1)
       || (ph > int'(bright)) || (sl == 0 && ph == 0);
    sp  = lz_sup && id > 0 && ((dat >> (4 * id)) == 16'h0);
    if (drk) return 12'hFFF;
    s = seg_lut[dat[4*id +: 4]];
    s[7] = ~dp[id];
    if (sp) s[6:0] = 7'h7F;
    return {~(4'b0001 << id), s};
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (n=%0d)", name, act, exp, last_n);
    end
  endtask

  task automatic step();
    logic [11:0] e;
    e = rst ? model(n) : 12'hFFF;
    last_n = n;
    @(posedge clk);
    #1;
    n = rst ? n + 1 : 0;
    check("model", {20'h0, sel, c}, {20'h0, e});
    if (sel !== 4'hF) check("onecold", $countones(~sel), 1);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic run_to(input int target);
    for (int k = 0; k < 4000 && last_n != target; k++) step();
    check("reach", last_n, target);
  endtask

  typedef struct {
    logic [15:0] dat;
    logic [3:0]  en, dp, bl, br;
    logic        lz;
    int          id;
    logic [3:0]  sel;
    logic [7:0]  c;
  } vec_t;

  vec_t vt [11];
  int cnt, cnt2;

  initial begin
    vt[0]  = '{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0, 0, 4'hE, 8'h99};
    vt[1]  = '{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0, 1, 4'hD, 8'hB0};
    vt[2]  = '{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0, 2, 4'hB, 8'hA4};
    vt[3]  = '{16'h1234, 4'hF, 4'h0, 4'h0, 4'hF, 1'b0, 3, 4'h7, 8'hF9};
    vt[4]  = '{16'h0050, 4'hF, 4'h4, 4'h0, 4'hF, 1'b1, 3, 4'h7, 8'hFF};
    vt[5]  = '{16'h0050, 4'hF, 4'h4, 4'h0, 4'hF, 1'b1, 2, 4'hB, 8'h7F};
    vt[6]  = '{16'h0050, 4'hF, 4'h4, 4'h0, 4'hF, 1'b1, 1, 4'hD, 8'h92};
    vt[7]  = '{16'h0050, 4'hF, 4'h4, 4'h0, 4'hF, 1'b1, 0, 4'hE, 8'hC0};
    vt[8]  = '{16'h0050, 4'hF, 4'h4, 4'h0, 4'hF, 1'b0, 3, 4'h7, 8'hC0};
    vt[9]  = '{16'h1234, 4'hB, 4'h0, 4'h0, 4'hF, 1'b0, 2, 4'hF, 8'hFF};
    vt[10] = '{16'h1234, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0, 1, 4'hD, 8'hB0};

    do_reset();
    check("reset_sel", {28'h0, sel}, 32'hF);
    check("reset_c", {24'h0, c}, 32'hFF);

    foreach (vt[i]) begin
      dat = vt[i].dat; en_in = vt[i].en; dp = vt[i].dp;
      blink = vt[i].bl; bright = vt[i].br; lz_sup = vt[i].lz;
      do_reset();
      run_to(vt[i].id * DW + 5);
      check($sformatf("vec%0d", i), {20'h0, sel, c},
            {20'h0, vt[i].sel, vt[i].c});
    end

    // first lit output two cycles after release
    dat = 16'h1234; en_in = 4'hF; dp = 4'h0; blink = 4'h0;
    bright = 4'hF; lz_sup = 1'b0;
    do_reset();
    step();
    check("post_rst_guard", {20'h0, sel, c}, 32'hFFF);
    step();
    check("post_rst_lit", {20'h0, sel, c}, {20'h0, 4'hE, 8'h99});

    // bright=3 duty over one frame
    bright = 4'h3;
    do_reset();
    cnt = 0;
    for (int k = 0; k < D * DW; k++) begin
      step();
      if (sel !== 4'hF) cnt++;
    end
    check("bright3_lit", cnt, 4 * 39);

    // blink digit 0 with two-frame half-period
    bright = 4'hF; blink = 4'b0001;
    do_reset();
    cnt = 0; cnt2 = 0;
    for (int k = 0; k < 2 * D * DW; k++) begin
      step();
      if (sel === 4'hE) cnt++;
      if (sel === 4'hD) cnt2++;
    end
    check("blink_on", cnt, 2 * 159);
    cnt = 0;
    for (int k = 0; k < 2 * D * DW; k++) begin
      step();
      if (sel === 4'hE) cnt++;
      if (sel === 4'hD) cnt2++;
    end
    check("blink_off", cnt, 0);
    check("blink_other", cnt2, 4 * 159);
    cnt = 0;
    for (int k = 0; k < D * DW; k++) begin
      step();
      if (sel === 4'hE) cnt++;
    end
    check("blink_on_again", cnt, 159);

    // reset held low for three edges mid-dwell of digit 2
    blink = 4'h0;
    do_reset();
    run_to(2 * DW + 50);
    rst = 1'b0;
    step();
    check("midrst_dark", {20'h0, sel, c}, 32'hFFF);
    step();
    step();
    rst = 1'b1;
    step();
    check("midrst_guard", {20'h0, sel, c}, 32'hFFF);
    step();
    check("midrst_d0", {20'h0, sel, c}, {20'h0, 4'hE, 8'h99});

    // random inputs, occasional resets, checked by the model every cycle
    for (int k = 0; k < 6000; k++) begin
      if (k % 23 == 0) begin
        dat    = 16'($urandom) & 16'($urandom);
        en_in  = 4'($urandom) | 4'($urandom);
        dp     = 4'($urandom);
        blink  = 4'($urandom) & 4'($urandom);
        bright = 4'($urandom);
        lz_sup = 1'($urandom);
      end
      rst = ($urandom_range(0, 499) != 0);
      step();
    end
    rst = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
